i281_phase_sequencer: RTL and testbench

- Multicycle phase controller for the i281 multicycle CPU.
- Sits between the combinational control-logic generator and the datapath registers, and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Gates the 18 control lines per phase and issues the IR and PC load strobes.
- Supports free-run and single-step execution and counts retired instructions.

---
 rtl/i281_seq_pkg.sv | 26 ++
 rtl/i281_phase_sequencer.sv | 126 ++++++++++++
 tb/tb_i281_phase_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i281_seq_pkg.sv
// Shared encodings and opcode class masks for the i281 multicycle phase sequencer.
package i281_seq_pkg;

   localparam int unsigned OP_W    = 23;
   localparam int unsigned CTRL_W  = 18;
   localparam int unsigned PHASE_W = 3;

   typedef enum logic [PHASE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5
   } state_e;

   // Load/store family needs a data-memory phase; most ops write back a register.
   localparam logic [OP_W-1:0] OP_MEM_MASK = 23'h00F000;
   localparam logic [OP_W-1:0] OP_WB_MASK  = 23'h033FFE;
   localparam int unsigned     OP_NOOP_BIT = 0;

   function automatic logic is_one_hot(input logic [OP_W-1:0] v);
      return (v != '0) && ((v & (v - OP_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/i281_phase_sequencer.sv
// Multicycle phase controller: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// gates the control word per phase and counts retired instructions.
module i281_phase_sequencer
   import i281_seq_pkg::*;
#(
   parameter logic [CTRL_W-1:0] EXEC_MASK = 18'h3FFFF,
   parameter logic [CTRL_W-1:0] MEM_MASK  = 18'h3FFFF,
   parameter logic [CTRL_W-1:0] WB_MASK   = 18'h3FFFF,
   parameter int unsigned       CNT_W     = 16
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               run_mode_i,
   input  logic               step_req_i,
   input  logic [OP_W-1:0]    op_in_i,
   input  logic [1:CTRL_W]    ctrl_in_i,
   input  logic               mem_ready_i,
   output logic [1:CTRL_W]    ctrl_out_o,
   output logic               ir_load_o,
   output logic               pc_load_o,
   output logic [PHASE_W-1:0] phase_o,
   output logic               busy_o,
   output logic               instr_done_o,
   output logic               illegal_op_o,
   output logic [CNT_W-1:0]   instr_count_o
);

   state_e             state_q, state_d;
   logic               illegal_q, illegal_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic op_mem;
   logic op_wb;
   logic op_legal;
   logic final_phase;

   assign op_mem   = |(op_in_i & OP_MEM_MASK);
   assign op_wb    = |(op_in_i & OP_WB_MASK);
   assign op_legal = is_one_hot(op_in_i);

   // Last phase of the current instruction: retire in this cycle.
   always_comb begin
      final_phase = 1'b0;
      unique case (state_q)
         ST_EXEC: final_phase = !op_mem && !op_wb;
         ST_MEM:  final_phase = mem_ready_i && !op_wb;
         ST_WB:   final_phase = 1'b1;
         default: final_phase = 1'b0;
      endcase
   end

   // State, sticky illegal flag and retired counter.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         illegal_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         count_q   <= count_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      count_d   = count_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!illegal_q && (run_mode_i || step_req_i)) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            if (op_legal) begin
               state_d = ST_EXEC;
            end else begin
               state_d   = ST_IDLE;
               illegal_d = 1'b1;
            end
         end
         ST_EXEC: begin
            if (op_mem) begin
               state_d = ST_MEM;
            end else if (op_wb) begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            if (mem_ready_i && op_wb) begin
               state_d = ST_WB;
            end
         end
         ST_WB:   state_d = ST_WB;
         default: state_d = ST_IDLE;
      endcase
      // Retirement overrides the per-phase successor.
      if (final_phase) begin
         state_d = run_mode_i ? ST_FETCH : ST_IDLE;
         count_d = count_q + CNT_W'(1);
      end
   end

   // Phase-decoded outputs.
   always_comb begin
      ctrl_out_o   = '0;
      ir_load_o    = 1'b0;
      pc_load_o    = final_phase;
      instr_done_o = final_phase;
      phase_o      = state_q;
      busy_o       = (state_q != ST_IDLE);
      illegal_op_o = illegal_q;
      instr_count_o = count_q;
      unique case (state_q)
         ST_FETCH: ir_load_o  = 1'b1;
         ST_EXEC:  ctrl_out_o = ctrl_in_i & EXEC_MASK;
         ST_MEM:   ctrl_out_o = ctrl_in_i & MEM_MASK;
         ST_WB:    ctrl_out_o = ctrl_in_i & WB_MASK;
         default:  ctrl_out_o = '0;
      endcase
   end

endmodule

// File: tb/tb_i281_phase_sequencer.sv
// Randomized bench for i281_phase_sequencer against an instruction-level phase-queue model.
module tb_i281_phase_sequencer;

   localparam logic [17:0] EXEC_M = 18'h3FFFF;
   localparam logic [17:0] MEM_M  = 18'h155F0;
   localparam logic [17:0] WB_M   = 18'h3FFFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, run_mode, step_req, mem_ready;
   logic [22:0] op_in;
   logic [1:18] ctrl_in;
   logic [1:18] ctrl_out;
   logic        ir_load, pc_load, busy, instr_done, illegal_op;
   logic [2:0]  phase;
   logic [15:0] instr_count;

   // Narrow-counter instance used only to observe wrap-around cheaply.
   logic        w_reset;
   logic [1:18] w_ctrl_out;
   logic        w_ir_load, w_pc_load, w_busy, w_instr_done, w_illegal_op;
   logic [2:0]  w_phase;
   logic [3:0]  w_instr_count;

   i281_phase_sequencer #(
      .EXEC_MASK(EXEC_M), .MEM_MASK(MEM_M), .WB_MASK(WB_M), .CNT_W(16)
   ) dut (
      .clk_i(clk), .reset_i(reset), .run_mode_i(run_mode), .step_req_i(step_req),
      .op_in_i(op_in), .ctrl_in_i(ctrl_in), .mem_ready_i(mem_ready),
      .ctrl_out_o(ctrl_out), .ir_load_o(ir_load), .pc_load_o(pc_load),
      .phase_o(phase), .busy_o(busy), .instr_done_o(instr_done),
      .illegal_op_o(illegal_op), .instr_count_o(instr_count)
   );

   i281_phase_sequencer #(.CNT_W(4)) dut_w (
      .clk_i(clk), .reset_i(w_reset), .run_mode_i(1'b1), .step_req_i(1'b0),
      .op_in_i(23'h000001), .ctrl_in_i(18'h0), .mem_ready_i(1'b1),
      .ctrl_out_o(w_ctrl_out), .ir_load_o(w_ir_load), .pc_load_o(w_pc_load),
      .phase_o(w_phase), .busy_o(w_busy), .instr_done_o(w_instr_done),
      .illegal_op_o(w_illegal_op), .instr_count_o(w_instr_count)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Model: queue of phases still to visit in the current instruction (empty = idle).
   int          q[$];
   bit          m_illegal = 1'b0;
   int unsigned m_count   = 0;

   // Trace of observed outputs for the directed scenarios.
   int          tr_n = 0;
   logic [3:0]  tr_ph   [16];
   logic        tr_pc   [16];
   logic        tr_ir   [16];
   logic        tr_done [16];
   logic        tr_ill  [16];
   logic [17:0] tr_ctrl [16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int m_phase();
      return (q.size() != 0) ? q[0] : 0;
   endfunction

   function automatic bit m_final();
      return (q.size() == 1) && (q[0] >= 3) && ((q[0] != 4) || mem_ready);
   endfunction

   function automatic bit is_mem_op(input logic [22:0] op);
      return |op[15:12];
   endfunction

   function automatic bit is_wb_op(input logic [22:0] op);
      return (|op[13:1]) || op[16] || op[17];
   endfunction

   task automatic compare_all();
      int ph;
      logic [17:0] exp_ctrl;
      ph = m_phase();
      case (ph)
         3:       exp_ctrl = ctrl_in & EXEC_M;
         4:       exp_ctrl = ctrl_in & MEM_M;
         5:       exp_ctrl = ctrl_in & WB_M;
         default: exp_ctrl = '0;
      endcase
      chk("phase",       64'(phase),       64'(ph));
      chk("busy",        64'(busy),        64'(ph != 0));
      chk("ir_load",     64'(ir_load),     64'(ph == 1));
      chk("pc_load",     64'(pc_load),     64'(m_final()));
      chk("instr_done",  64'(instr_done),  64'(m_final()));
      chk("illegal_op",  64'(illegal_op),  64'(m_illegal));
      chk("instr_count", 64'(instr_count), 64'(m_count));
      chk("ctrl_out",    64'(ctrl_out),    64'(exp_ctrl));
   endtask

   task automatic model_advance();
      int ph;
      bit fin;
      ph  = m_phase();
      fin = m_final();
      if (reset) begin
         q.delete();
         m_illegal = 1'b0;
         m_count   = 0;
      end else if (q.size() == 0) begin
         if (!m_illegal && (run_mode || step_req)) q = '{1, 2};
      end else if (!(ph == 4 && !mem_ready)) begin
         void'(q.pop_front());
         if (ph == 2) begin
            if ($countones(op_in) != 1) begin
               m_illegal = 1'b1;
            end else begin
               q.push_back(3);
               if (is_mem_op(op_in)) q.push_back(4);
               if (is_wb_op(op_in))  q.push_back(5);
            end
         end
         if (fin) begin
            m_count = (m_count + 1) % 65536;
            if (run_mode) q = '{1, 2};
         end
      end
   endtask

   // One cycle: inputs already driven at the falling edge.
   task automatic tick();
      #1;
      compare_all();
      if (tr_n < 16) begin
         tr_ph[tr_n]   = 4'(phase);
         tr_pc[tr_n]   = pc_load;
         tr_ir[tr_n]   = ir_load;
         tr_done[tr_n] = instr_done;
         tr_ill[tr_n]  = illegal_op;
         tr_ctrl[tr_n] = ctrl_out;
         tr_n++;
      end
      model_advance();
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [63:0] pack_ph(input int n);
      logic [63:0] r = '0;
      for (int i = 0; i < n; i++) r = (r << 4) | 64'(tr_ph[i]);
      return r;
   endfunction

   function automatic logic [63:0] bits_pc(input int n);
      logic [63:0] r = '0;
      for (int i = 0; i < n; i++) r[i] = tr_pc[i];
      return r;
   endfunction

   function automatic logic [63:0] bits_ir(input int n);
      logic [63:0] r = '0;
      for (int i = 0; i < n; i++) r[i] = tr_ir[i];
      return r;
   endfunction

   function automatic logic [63:0] bits_done(input int n);
      logic [63:0] r = '0;
      for (int i = 0; i < n; i++) r[i] = tr_done[i];
      return r;
   endfunction

   function automatic logic [22:0] gen_op();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return 23'($urandom);
      if (r == 1) return 23'h0;
      return 23'(1) << $urandom_range(0, 22);
   endfunction

   initial begin
      int nret;
      reset = 1'b1; run_mode = 1'b0; step_req = 1'b0; mem_ready = 1'b0;
      op_in = 23'h000001; ctrl_in = 18'h2AAAA; w_reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);

      // Reset released, idle for 10 cycles.
      reset = 1'b0;
      ticks(10);
      chk("idle_phase", 64'(phase), 64'd0);
      chk("idle_count", 64'(instr_count), 64'd0);

      // Single-step ALU op (bit 8): FETCH, DECODE, EXEC, WB.
      tr_n = 0; op_in = 23'h000100; ctrl_in = 18'h2AAAA;
      step_req = 1'b1; tick(); step_req = 1'b0; ticks(5);
      chk("alu_phases",  pack_ph(6), 64'h012350);
      chk("alu_ir_load", bits_ir(6), 64'b000010);
      chk("alu_pc_load", bits_pc(6), 64'b010000);
      chk("alu_ctrl_ex", 64'(tr_ctrl[3]), 64'h2AAAA);
      chk("alu_ctrl_wb", 64'(tr_ctrl[4]), 64'h2AAAA);
      chk("alu_ctrl_dc", 64'(tr_ctrl[2]), 64'h0);
      chk("alu_count",   64'(instr_count), 64'd1);

      // Load (bit 12) with three memory wait cycles.
      tr_n = 0; op_in = 23'h001000; mem_ready = 1'b0;
      step_req = 1'b1; tick(); step_req = 1'b0; ticks(6);
      mem_ready = 1'b1; ticks(3);
      chk("ld_phases",   pack_ph(10), 64'h0123444450);
      chk("ld_done",     bits_done(10), 64'b0100000000);
      chk("ld_ctrl_mem", 64'(tr_ctrl[4]), 64'h000A0);
      chk("ld_count",    64'(instr_count), 64'd2);

      // Free-running NOOPs.
      tr_n = 0; run_mode = 1'b1; op_in = 23'h000001;
      ticks(9);
      chk("noop_phases",  pack_ph(9), 64'h012312312);
      chk("noop_pc_load", bits_pc(9), 64'b001001000);
      run_mode = 1'b0; ticks(3);
      chk("noop_idle",  64'(phase), 64'd0);
      chk("noop_count", 64'(instr_count), 64'd5);

      // Reset while waiting in MEM.
      tr_n = 0; op_in = 23'h004000; mem_ready = 1'b0;
      step_req = 1'b1; tick(); step_req = 1'b0; ticks(3);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rst_mem_phase", 64'(tr_ph[4]), 64'd4);
      chk("rst_mem_ctrl",  64'(tr_ctrl[4]), 64'h000A0);
      chk("rst_count",     64'(instr_count), 64'd0);
      tick();
      chk("rst_phase", 64'(tr_ph[5]), 64'd0);
      chk("rst_ctrl",  64'(tr_ctrl[5]), 64'h0);

      // Stray step request during EXEC is dropped.
      tr_n = 0; op_in = 23'h000100; mem_ready = 1'b1;
      step_req = 1'b1; tick(); step_req = 1'b0; ticks(2);
      step_req = 1'b1; tick(); step_req = 1'b0; ticks(3);
      chk("stray_phases", pack_ph(7), 64'h0123500);
      chk("stray_count",  64'(instr_count), 64'd1);

      // Illegal opcode locks the sequencer until reset.
      tr_n = 0; op_in = 23'h000003;
      step_req = 1'b1; tick(); step_req = 1'b0; ticks(2);
      step_req = 1'b1; tick(); step_req = 1'b0; tick();
      chk("ill_phases", pack_ph(5), 64'h01200);
      chk("ill_flag",   64'(tr_ill[3]), 64'd1);
      chk("ill_pc",     bits_pc(5), 64'd0);
      reset = 1'b1; tick(); reset = 1'b0; tick();
      chk("ill_cleared", 64'(illegal_op), 64'd0);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 59) == 0);
         if (m_phase() <= 1) op_in = gen_op();
         ctrl_in   = 18'($urandom);
         mem_ready = ($urandom_range(0, 2) != 0);
         step_req  = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 19) == 0) run_mode = ~run_mode;
         tick();
      end

      // Counter wrap on the 4-bit instance.
      reset = 1'b1; run_mode = 1'b0; step_req = 1'b0; tick(); reset = 1'b0;
      w_reset = 1'b0;
      nret = 0;
      for (int c = 0; c < 60; c++) begin
         chk("wrap_count", 64'(w_instr_count), 64'(nret % 16));
         if (w_instr_done) nret++;
         tick();
      end
      chk("wrap_retired", 64'(nret >= 17), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
